multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter FETCH_WAIT, default 1, meaning extra instruction-memory wait cycles after FETCH (0..7).
REQ-002 Parameter MEM_TIMEOUT, default 15, meaning max cycles LBRD/SBWR wait for mem_ready before abort (1..255).
REQ-003 Parameter PROTECT_MASK, default 16'hC000, meaning destination registers whose ALU/shift writeback is suppressed.
REQ-004 Parameter IRQ_EN_BIT, default 5, meaning PSR bit enabling interrupts.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 opCode1, opCode2, conditionCode  in  4 each  instruction fields; conditionCode is also the destination register index.
REQ-008 PSR  in  8  flags; bits 4..0 are condition flags, bit IRQ_EN_BIT is interrupt enable.
REQ-009 mem_ready  in  1  data-memory handshake, valid in LBRD/SBWR only.
REQ-010 irq  in  1  level interrupt request.
REQ-011 PCEN, PCinstruction, nextInstruction, immediateRegEN, SrcB, zeroExtend, resultEN, PSREN, regWriteEN, updateAddress, writeData, storeReg, wren_a  out  1 each  datapath strobes and selects.
REQ-012 BranchEN, JmpEN, JALEN  out  1 each  PC redirect enables.
REQ-013 ALUcontrol, shifterControl  out  4 each; result  out  2  writeback select.
REQ-014 irq_ack, vector_sel, mem_err, illegal  out  1 each  event pulses/selects.
REQ-015 state_o  out  5  current state encoding for debug.

Function
REQ-016 All outputs SHALL be Moore-decoded from the state register (plus opCode/conditionCode/PSR fields); defaults zeroExtend=1, SrcB=1, updateAddress=1, writeData=1, ALUcontrol=5, result=1, all others 0.
REQ-017 States: FETCH, FWAIT, DECODE, RTYPEEX, RTYPEWR, ITYPEEX, ITYPEWR, SHIFTEX, SHIFTWR, MEMADR, LBRD, LBWR, SBWR, BCONDEX, JALEX, JALWR, JCONDEX, IRQ, IRQWR.
REQ-018 FETCH: PCEN, PCinstruction, nextInstruction high; -> FWAIT if FETCH_WAIT>0 else DECODE.
REQ-019 FWAIT: nextInstruction high, wait counter counts FETCH_WAIT cycles then -> DECODE.
REQ-020 DECODE: SrcB=0, immediateRegEN=1; zeroExtend=1 only for opCode1 in {1,2,3,D}, else 0; dispatch opCode1: 0->RTYPEEX, 4->MEMADR, 8 or F->SHIFTEX, {1,2,3,5,9,B,D}->ITYPEEX, C->BCONDEX, other->FETCH with illegal pulsed one cycle.
REQ-021 MEMADR dispatch opCode2: 0->LBRD, 4->SBWR, 8->JALEX, C->JCONDEX, other->FETCH with illegal pulsed.
REQ-022 LBRD: updateAddress=0; stays until mem_ready=1, then -> LBWR. LBWR: writeData=0, regWriteEN=1, -> FETCH.
REQ-023 SBWR: storeReg=1, updateAddress=0, wren_a=1 while waiting; -> FETCH on mem_ready=1.
REQ-024 Wait counter in LBRD/SBWR: on MEM_TIMEOUT consecutive cycles without mem_ready, mem_err pulses one cycle, no regWriteEN, -> FETCH.
REQ-025 RTYPEEX: ALUcontrol=opCode2; PSREN, resultEN high unless opCode2=0. RTYPEWR: regWriteEN unless opCode2=B or PROTECT_MASK[conditionCode]=1.
REQ-026 ITYPEEX: ALUcontrol=opCode1, SrcB=0, PSREN, resultEN. ITYPEWR: regWriteEN unless opCode1=B or PROTECT_MASK[conditionCode]=1.
REQ-027 SHIFTEX: result=0, resultEN=1; opCode1=F: SrcB=0, shifterControl=F; else shifterControl=opCode2, SrcB=(opCode2==4). SHIFTWR: regWriteEN.
REQ-028 BCONDEX: BranchEN=pass, PCinstruction, PCEN, SrcB=0, zeroExtend=0. JCONDEX: JmpEN=pass, PCinstruction, PCEN. JALEX: JALEN, PCinstruction, PCEN, result=3, resultEN; JALWR: regWriteEN.
REQ-029 pass by conditionCode (P=PSR): 0:P4 1:!P4 2:P3 3:!P3 4:P0 5:!P0 6:P1 7:!P1 8:P2 9:!P2 A:!P4&!P0 B:P4|P0 C:!P1&!P4 D:P4|P1 E:1 F:0.
REQ-030 Interrupt: at every transition into FETCH, if irq=1 and PSR[IRQ_EN_BIT]=1, enter IRQ instead; irq during an instruction SHALL NOT abort it.
REQ-031 IRQ: irq_ack, vector_sel, JALEN, PCEN, result=3, resultEN high one cycle; IRQWR: vector_sel, regWriteEN, -> FETCH.
REQ-032 Unreachable state encodings SHALL return to FETCH next cycle with all outputs at defaults.

Reset
REQ-033 reset=0 SHALL immediately force state FETCH and clear wait counters, regardless of clk, including mid-wait in LBRD/SBWR.
REQ-034 While reset=0 outputs SHALL equal FETCH decode; first post-reset edge moves to FWAIT/DECODE.

Verification
REQ-035 FETCH_WAIT=2, ADDI (opCode1=5, cond=3): FETCH,FWAIT,FWAIT,DECODE,ITYPEEX,ITYPEWR; regWriteEN=1 in ITYPEWR only.
REQ-036 LB with mem_ready rising on 3rd LBRD cycle: LBWR follows, regWriteEN one cycle; with mem_ready held 0, mem_err pulses after 15 cycles, no write.
REQ-037 RTYPE ADD dest=15: PSREN/resultEN in RTYPEEX, regWriteEN stays 0 in RTYPEWR.
REQ-038 BCOND cond=0 with PSR=8'h10 -> BranchEN=1; PSR=8'h00 -> BranchEN=0; PCEN=1 both.
REQ-039 irq=1, PSR[5]=1 asserted mid-SHIFTEX: SHIFTWR completes, then IRQ (irq_ack one cycle), IRQWR, FETCH; PSR[5]=0 -> no IRQ.
REQ-040 reset pulled low mid-SBWR between edges: state_o=FETCH and wren_a=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle CPU control FSM with wait-state fetch, data-memory
//            handshake timeout, protected writeback and level interrupts.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int          FETCH_WAIT   = 1,
    parameter int          MEM_TIMEOUT  = 15,
    parameter logic [15:0] PROTECT_MASK = 16'hC000,
    parameter int          IRQ_EN_BIT   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opCode1,
    input  logic [3:0] opCode2,
    input  logic [3:0] conditionCode,
    input  logic [7:0] PSR,
    input  logic       mem_ready,
    input  logic       irq,
    output logic       PCEN,
    output logic       PCinstruction,
    output logic       nextInstruction,
    output logic       immediateRegEN,
    output logic       SrcB,
    output logic       zeroExtend,
    output logic       resultEN,
    output logic       PSREN,
    output logic       regWriteEN,
    output logic       updateAddress,
    output logic       writeData,
    output logic       storeReg,
    output logic       wren_a,
    output logic       BranchEN,
    output logic       JmpEN,
    output logic       JALEN,
    output logic [3:0] ALUcontrol,
    output logic [3:0] shifterControl,
    output logic [1:0] result,
    output logic       irq_ack,
    output logic       vector_sel,
    output logic       mem_err,
    output logic       illegal,
    output logic [4:0] state_o
);

    localparam logic [4:0] c_FETCH   = 5'd0;
    localparam logic [4:0] c_FWAIT   = 5'd1;
    localparam logic [4:0] c_DECODE  = 5'd2;
    localparam logic [4:0] c_RTYPEEX = 5'd3;
    localparam logic [4:0] c_RTYPEWR = 5'd4;
    localparam logic [4:0] c_ITYPEEX = 5'd5;
    localparam logic [4:0] c_ITYPEWR = 5'd6;
    localparam logic [4:0] c_SHIFTEX = 5'd7;
    localparam logic [4:0] c_SHIFTWR = 5'd8;
    localparam logic [4:0] c_MEMADR  = 5'd9;
    localparam logic [4:0] c_LBRD    = 5'd10;
    localparam logic [4:0] c_LBWR    = 5'd11;
    localparam logic [4:0] c_SBWR    = 5'd12;
    localparam logic [4:0] c_BCONDEX = 5'd13;
    localparam logic [4:0] c_JALEX   = 5'd14;
    localparam logic [4:0] c_JALWR   = 5'd15;
    localparam logic [4:0] c_JCONDEX = 5'd16;
    localparam logic [4:0] c_IRQ     = 5'd17;
    localparam logic [4:0] c_IRQWR   = 5'd18;

    localparam logic [7:0] c_FWAIT_LAST = 8'(FETCH_WAIT - 1);
    localparam logic [7:0] c_MEM_LAST   = 8'(MEM_TIMEOUT - 1);

    logic [4:0] r_state;
    logic [7:0] r_wait;
    logic       r_mem_err;
    logic       w_pass;
    logic       w_op1_illegal;
    logic       w_op2_illegal;
    logic [4:0] w_to_fetch;
    logic       w_unused_psr;

    // Interrupts are only taken on the way back to FETCH, so instructions never abort.
    assign w_to_fetch    = (irq && PSR[IRQ_EN_BIT]) ? c_IRQ : c_FETCH;
    assign w_op1_illegal = !(opCode1 inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8,
                                             4'h9, 4'hB, 4'hC, 4'hD, 4'hF});
    assign w_op2_illegal = !(opCode2 inside {4'h0, 4'h4, 4'h8, 4'hC});
    assign w_unused_psr  = &{1'b0, PSR};
    assign mem_err       = r_mem_err;
    assign state_o       = r_state;

    always_comb begin
        w_pass = 1'b0;
        case (conditionCode)
            4'h0: w_pass = PSR[4];
            4'h1: w_pass = !PSR[4];
            4'h2: w_pass = PSR[3];
            4'h3: w_pass = !PSR[3];
            4'h4: w_pass = PSR[0];
            4'h5: w_pass = !PSR[0];
            4'h6: w_pass = PSR[1];
            4'h7: w_pass = !PSR[1];
            4'h8: w_pass = PSR[2];
            4'h9: w_pass = !PSR[2];
            4'hA: w_pass = !PSR[4] && !PSR[0];
            4'hB: w_pass = PSR[4] || PSR[0];
            4'hC: w_pass = !PSR[1] && !PSR[4];
            4'hD: w_pass = PSR[4] || PSR[1];
            4'hE: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_FETCH;
            r_wait    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            r_wait    <= 8'd0;
            case (r_state)
                c_FETCH:   r_state <= (FETCH_WAIT > 0) ? c_FWAIT : c_DECODE;
                c_FWAIT: begin
                    if (r_wait == c_FWAIT_LAST) r_state <= c_DECODE;
                    else                        r_wait  <= r_wait + 8'd1;
                end
                c_DECODE: begin
                    case (opCode1)
                        4'h0:                                     r_state <= c_RTYPEEX;
                        4'h4:                                     r_state <= c_MEMADR;
                        4'h8, 4'hF:                               r_state <= c_SHIFTEX;
                        4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: r_state <= c_ITYPEEX;
                        4'hC:                                     r_state <= c_BCONDEX;
                        default:                                  r_state <= w_to_fetch;
                    endcase
                end
                c_MEMADR: begin
                    case (opCode2)
                        4'h0:    r_state <= c_LBRD;
                        4'h4:    r_state <= c_SBWR;
                        4'h8:    r_state <= c_JALEX;
                        4'hC:    r_state <= c_JCONDEX;
                        default: r_state <= w_to_fetch;
                    endcase
                end
                c_LBRD, c_SBWR: begin
                    if (mem_ready) begin
                        r_state <= (r_state == c_LBRD) ? c_LBWR : w_to_fetch;
                    end else if (r_wait == c_MEM_LAST) begin
                        r_state   <= w_to_fetch;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                c_RTYPEEX: r_state <= c_RTYPEWR;
                c_ITYPEEX: r_state <= c_ITYPEWR;
                c_SHIFTEX: r_state <= c_SHIFTWR;
                c_JALEX:   r_state <= c_JALWR;
                c_IRQ:     r_state <= c_IRQWR;
                c_RTYPEWR, c_ITYPEWR, c_SHIFTWR, c_LBWR, c_BCONDEX,
                c_JALWR, c_JCONDEX, c_IRQWR: r_state <= w_to_fetch;
                default:   r_state <= c_FETCH;
            endcase
        end
    end

    always_comb begin
        PCEN = 1'b0;          PCinstruction = 1'b0;  nextInstruction = 1'b0;
        immediateRegEN = 1'b0; SrcB = 1'b1;          zeroExtend = 1'b1;
        resultEN = 1'b0;      PSREN = 1'b0;          regWriteEN = 1'b0;
        updateAddress = 1'b1; writeData = 1'b1;      storeReg = 1'b0;
        wren_a = 1'b0;        BranchEN = 1'b0;       JmpEN = 1'b0;
        JALEN = 1'b0;         ALUcontrol = 4'h5;     shifterControl = 4'h0;
        result = 2'd1;        irq_ack = 1'b0;        vector_sel = 1'b0;
        illegal = 1'b0;
        case (r_state)
            c_FETCH: begin
                PCEN = 1'b1; PCinstruction = 1'b1; nextInstruction = 1'b1;
            end
            c_FWAIT: nextInstruction = 1'b1;
            c_DECODE: begin
                SrcB           = 1'b0;
                immediateRegEN = 1'b1;
                zeroExtend     = opCode1 inside {4'h1, 4'h2, 4'h3, 4'hD};
                illegal        = w_op1_illegal;
            end
            c_MEMADR:  illegal = w_op2_illegal;
            c_LBRD:    updateAddress = 1'b0;
            c_LBWR: begin
                writeData = 1'b0; regWriteEN = 1'b1;
            end
            c_SBWR: begin
                storeReg = 1'b1; updateAddress = 1'b0; wren_a = 1'b1;
            end
            c_RTYPEEX: begin
                ALUcontrol = opCode2;
                PSREN      = (opCode2 != 4'h0);
                resultEN   = (opCode2 != 4'h0);
            end
            c_RTYPEWR: regWriteEN = (opCode2 != 4'hB) && !PROTECT_MASK[conditionCode];
            c_ITYPEEX: begin
                ALUcontrol = opCode1; SrcB = 1'b0; PSREN = 1'b1; resultEN = 1'b1;
            end
            c_ITYPEWR: regWriteEN = (opCode1 != 4'hB) && !PROTECT_MASK[conditionCode];
            c_SHIFTEX: begin
                result   = 2'd0;
                resultEN = 1'b1;
                if (opCode1 == 4'hF) begin
                    SrcB = 1'b0; shifterControl = 4'hF;
                end else begin
                    SrcB = (opCode2 == 4'h4); shifterControl = opCode2;
                end
            end
            c_SHIFTWR: regWriteEN = 1'b1;
            c_BCONDEX: begin
                BranchEN = w_pass; PCinstruction = 1'b1; PCEN = 1'b1;
                SrcB = 1'b0; zeroExtend = 1'b0;
            end
            c_JCONDEX: begin
                JmpEN = w_pass; PCinstruction = 1'b1; PCEN = 1'b1;
            end
            c_JALEX: begin
                JALEN = 1'b1; PCinstruction = 1'b1; PCEN = 1'b1;
                result = 2'd3; resultEN = 1'b1;
            end
            c_JALWR:   regWriteEN = 1'b1;
            c_IRQ: begin
                irq_ack = 1'b1; vector_sel = 1'b1; JALEN = 1'b1; PCEN = 1'b1;
                result = 2'd3; resultEN = 1'b1;
            end
            c_IRQWR: begin
                vector_sel = 1'b1; regWriteEN = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl (FETCH_WAIT=2).
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [4:0] S_FETCH = 5'd0,  S_FWAIT = 5'd1,  S_DECODE = 5'd2,
                           S_RTYPEEX = 5'd3, S_RTYPEWR = 5'd4, S_ITYPEEX = 5'd5,
                           S_ITYPEWR = 5'd6, S_SHIFTEX = 5'd7, S_SHIFTWR = 5'd8,
                           S_MEMADR = 5'd9, S_LBRD = 5'd10, S_LBWR = 5'd11,
                           S_SBWR = 5'd12, S_BCONDEX = 5'd13, S_IRQ = 5'd17,
                           S_IRQWR = 5'd18;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opCode1 = 4'h0, opCode2 = 4'h0, conditionCode = 4'h0;
    logic [7:0] PSR = 8'h00;
    logic       mem_ready = 1'b0, irq = 1'b0;
    logic       PCEN, PCinstruction, nextInstruction, immediateRegEN, SrcB, zeroExtend;
    logic       resultEN, PSREN, regWriteEN, updateAddress, writeData, storeReg, wren_a;
    logic       BranchEN, JmpEN, JALEN, irq_ack, vector_sel, mem_err, illegal;
    logic [3:0] ALUcontrol, shifterControl;
    logic [1:0] result;
    logic [4:0] state_o;

    int checks = 0;
    int failures = 0;

    // condition-code vectors: {cond, PSR, expected pass}
    logic [12:0] bc_vec [0:17] = '{
        {4'h1, 8'h00, 1'b1}, {4'h2, 8'h08, 1'b1}, {4'h3, 8'h08, 1'b0}, {4'h4, 8'h01, 1'b1},
        {4'h5, 8'h01, 1'b0}, {4'h6, 8'h02, 1'b1}, {4'h7, 8'h00, 1'b1}, {4'h8, 8'h04, 1'b1},
        {4'h9, 8'h04, 1'b0}, {4'hA, 8'h00, 1'b1}, {4'hA, 8'h01, 1'b0}, {4'hB, 8'h10, 1'b1},
        {4'hB, 8'h00, 1'b0}, {4'hC, 8'h00, 1'b1}, {4'hC, 8'h02, 1'b0}, {4'hD, 8'h02, 1'b1},
        {4'hE, 8'h00, 1'b1}, {4'hF, 8'hFF, 1'b0}};

    multicycle_ctrl #(.FETCH_WAIT(2), .MEM_TIMEOUT(15), .PROTECT_MASK(16'hC000), .IRQ_EN_BIT(5)) dut (
        .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2),
        .conditionCode(conditionCode), .PSR(PSR), .mem_ready(mem_ready), .irq(irq),
        .PCEN(PCEN), .PCinstruction(PCinstruction), .nextInstruction(nextInstruction),
        .immediateRegEN(immediateRegEN), .SrcB(SrcB), .zeroExtend(zeroExtend),
        .resultEN(resultEN), .PSREN(PSREN), .regWriteEN(regWriteEN),
        .updateAddress(updateAddress), .writeData(writeData), .storeReg(storeReg),
        .wren_a(wren_a), .BranchEN(BranchEN), .JmpEN(JmpEN), .JALEN(JALEN),
        .ALUcontrol(ALUcontrol), .shifterControl(shifterControl), .result(result),
        .irq_ack(irq_ack), .vector_sel(vector_sel), .mem_err(mem_err),
        .illegal(illegal), .state_o(state_o));

    always #50 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // FETCH -> FWAIT -> FWAIT -> DECODE
    task automatic to_decode;
        step; step; step;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (state_o !== S_FETCH) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_o, S_FETCH); end
        checks++; if ({PCEN, PCinstruction, nextInstruction} !== 3'b111) begin failures++; $display("FAIL rst_fetch_strobes got=%b exp=111", {PCEN, PCinstruction, nextInstruction}); end
        checks++; if ({ALUcontrol, zeroExtend, SrcB, result, regWriteEN, mem_err} !== 10'b0101_1_1_01_0_0) begin failures++; $display("FAIL rst_defaults got=%b exp=0101110100", {ALUcontrol, zeroExtend, SrcB, result, regWriteEN, mem_err}); end
        step;
        checks++; if (state_o !== S_FETCH) begin failures++; $display("FAIL rst_held got=%0d exp=%0d", state_o, S_FETCH); end
        reset = 1'b1;
        step;
        checks++; if (state_o !== S_FWAIT || nextInstruction !== 1'b1 || PCEN !== 1'b0) begin failures++; $display("FAIL rst_fwait state=%0d nI=%b PCEN=%b exp state=1 nI=1 PCEN=0", state_o, nextInstruction, PCEN); end
        step;
        opCode1 = 4'h6;
        step;
        checks++; if (state_o !== S_DECODE || illegal !== 1'b1) begin failures++; $display("FAIL illegal_op1 state=%0d illegal=%b exp state=2 illegal=1", state_o, illegal); end
        step;
        checks++; if (state_o !== S_FETCH || illegal !== 1'b0) begin failures++; $display("FAIL illegal_clear state=%0d illegal=%b exp state=0 illegal=0", state_o, illegal); end
    endtask

    task automatic test_addi;
        opCode1 = 4'h5; opCode2 = 4'h0; conditionCode = 4'h3;
        step;
        checks++; if (state_o !== S_FWAIT) begin failures++; $display("FAIL addi_fwait1 got=%0d exp=%0d", state_o, S_FWAIT); end
        step;
        checks++; if (state_o !== S_FWAIT) begin failures++; $display("FAIL addi_fwait2 got=%0d exp=%0d", state_o, S_FWAIT); end
        step;
        checks++; if (state_o !== S_DECODE || {SrcB, immediateRegEN, zeroExtend} !== 3'b010) begin failures++; $display("FAIL addi_decode state=%0d SrcB/imm/zx=%b exp state=2 010", state_o, {SrcB, immediateRegEN, zeroExtend}); end
        opCode1 = 4'hD; #1;
        checks++; if (zeroExtend !== 1'b1) begin failures++; $display("FAIL decode_zx_D got=%b exp=1", zeroExtend); end
        opCode1 = 4'h5; #1;
        step;
        checks++; if (state_o !== S_ITYPEEX || ALUcontrol !== 4'h5 || {SrcB, PSREN, resultEN, regWriteEN} !== 4'b0110) begin failures++; $display("FAIL addi_ex state=%0d alu=%h SrcB/PSREN/resEN/wr=%b exp 5 5 0110", state_o, ALUcontrol, {SrcB, PSREN, resultEN, regWriteEN}); end
        step;
        checks++; if (state_o !== S_ITYPEWR || regWriteEN !== 1'b1) begin failures++; $display("FAIL addi_wr state=%0d wr=%b exp 6 1", state_o, regWriteEN); end
        step;
        checks++; if (state_o !== S_FETCH || regWriteEN !== 1'b0) begin failures++; $display("FAIL addi_done state=%0d wr=%b exp 0 0", state_o, regWriteEN); end
    endtask

    task automatic test_lb;
        opCode1 = 4'h4; opCode2 = 4'h0; conditionCode = 4'h1;
        to_decode; step;
        checks++; if (state_o !== S_MEMADR || illegal !== 1'b0) begin failures++; $display("FAIL lb_memadr state=%0d illegal=%b exp 9 0", state_o, illegal); end
        step;
        checks++; if (state_o !== S_LBRD || updateAddress !== 1'b0 || regWriteEN !== 1'b0) begin failures++; $display("FAIL lb_rd state=%0d upd=%b wr=%b exp 10 0 0", state_o, updateAddress, regWriteEN); end
        step; step;
        checks++; if (state_o !== S_LBRD) begin failures++; $display("FAIL lb_rd3 got=%0d exp=%0d", state_o, S_LBRD); end
        mem_ready = 1'b1;
        step;
        mem_ready = 1'b0;
        checks++; if (state_o !== S_LBWR || {writeData, regWriteEN} !== 2'b01) begin failures++; $display("FAIL lb_wr state=%0d wd/wr=%b exp 11 01", state_o, {writeData, regWriteEN}); end
        step;
        checks++; if (state_o !== S_FETCH || regWriteEN !== 1'b0 || mem_err !== 1'b0) begin failures++; $display("FAIL lb_done state=%0d wr=%b err=%b exp 0 0 0", state_o, regWriteEN, mem_err); end
    endtask

    task automatic test_lb_timeout;
        opCode1 = 4'h4; opCode2 = 4'h0;
        to_decode; step; step;
        for (int i = 0; i < 14; i++) begin
            step;
            checks++; if (state_o !== S_LBRD || mem_err !== 1'b0 || regWriteEN !== 1'b0) begin failures++; $display("FAIL lb_to_wait%0d state=%0d err=%b wr=%b exp 10 0 0", i, state_o, mem_err, regWriteEN); end
        end
        step;
        checks++; if (state_o !== S_FETCH || mem_err !== 1'b1 || regWriteEN !== 1'b0) begin failures++; $display("FAIL lb_to_abort state=%0d err=%b wr=%b exp 0 1 0", state_o, mem_err, regWriteEN); end
        opCode1 = 4'h6;
        step;
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL lb_to_pulse got=%b exp=0", mem_err); end
        step; step; step;
    endtask

    task automatic test_rtype;
        for (int k = 0; k < 2; k++) begin
            opCode1 = 4'h0; opCode2 = 4'h5; conditionCode = (k == 0) ? 4'hF : 4'h2;
            to_decode; step;
            checks++; if (state_o !== S_RTYPEEX || ALUcontrol !== 4'h5 || {PSREN, resultEN} !== 2'b11) begin failures++; $display("FAIL rtype_ex%0d state=%0d alu=%h ps/re=%b exp 3 5 11", k, state_o, ALUcontrol, {PSREN, resultEN}); end
            opCode2 = 4'h0; #1;
            checks++; if ({PSREN, resultEN} !== 2'b00) begin failures++; $display("FAIL rtype_nop%0d got=%b exp=00", k, {PSREN, resultEN}); end
            opCode2 = 4'h5; #1;
            step;
            checks++; if (state_o !== S_RTYPEWR || regWriteEN !== (k == 1)) begin failures++; $display("FAIL rtype_wr%0d state=%0d wr=%b exp 4 %0d", k, state_o, regWriteEN, k); end
            step;
        end
    endtask

    task automatic test_bcond;
        opCode1 = 4'hC; conditionCode = 4'h0; PSR = 8'h10;
        to_decode; step;
        checks++; if (state_o !== S_BCONDEX || {BranchEN, PCEN, PCinstruction, SrcB, zeroExtend} !== 5'b11100) begin failures++; $display("FAIL bcond_taken state=%0d got=%b exp 13 11100", state_o, {BranchEN, PCEN, PCinstruction, SrcB, zeroExtend}); end
        for (int i = 0; i < 18; i++) begin
            logic [12:0] v;
            v = bc_vec[i];
            conditionCode = v[12:9]; PSR = v[8:1]; #1;
            checks++; if (BranchEN !== v[0]) begin failures++; $display("FAIL bcond_cc%0h psr=%h got=%b exp=%b", v[12:9], v[8:1], BranchEN, v[0]); end
        end
        conditionCode = 4'h0; PSR = 8'h00;
        step;
        to_decode; step;
        checks++; if (state_o !== S_BCONDEX || {BranchEN, PCEN} !== 2'b01) begin failures++; $display("FAIL bcond_not state=%0d br/pcen=%b exp 13 01", state_o, {BranchEN, PCEN}); end
        step;
        checks++; if (state_o !== S_FETCH) begin failures++; $display("FAIL bcond_done got=%0d exp=0", state_o); end
    endtask

    task automatic test_irq;
        opCode1 = 4'h8; opCode2 = 4'h2; conditionCode = 4'h4; PSR = 8'h20; irq = 1'b0;
        to_decode; step;
        checks++; if (state_o !== S_SHIFTEX || result !== 2'd0 || resultEN !== 1'b1 || shifterControl !== 4'h2 || SrcB !== 1'b0) begin failures++; $display("FAIL shift_ex state=%0d res=%0d re=%b sh=%h srcb=%b exp 7 0 1 2 0", state_o, result, resultEN, shifterControl, SrcB); end
        opCode2 = 4'h4; #1;
        checks++; if (shifterControl !== 4'h4 || SrcB !== 1'b1) begin failures++; $display("FAIL shift_imm sh=%h srcb=%b exp 4 1", shifterControl, SrcB); end
        opCode1 = 4'hF; #1;
        checks++; if (shifterControl !== 4'hF || SrcB !== 1'b0) begin failures++; $display("FAIL shift_F sh=%h srcb=%b exp F 0", shifterControl, SrcB); end
        opCode1 = 4'h8; opCode2 = 4'h2; irq = 1'b1;
        step;
        checks++; if (state_o !== S_SHIFTWR || regWriteEN !== 1'b1 || irq_ack !== 1'b0) begin failures++; $display("FAIL irq_shiftwr state=%0d wr=%b ack=%b exp 8 1 0", state_o, regWriteEN, irq_ack); end
        step;
        irq = 1'b0;
        checks++; if (state_o !== S_IRQ || {irq_ack, vector_sel, JALEN, PCEN, resultEN} !== 5'b11111 || result !== 2'd3) begin failures++; $display("FAIL irq_enter state=%0d strobes=%b res=%0d exp 17 11111 3", state_o, {irq_ack, vector_sel, JALEN, PCEN, resultEN}, result); end
        step;
        checks++; if (state_o !== S_IRQWR || {irq_ack, vector_sel, regWriteEN} !== 3'b011) begin failures++; $display("FAIL irq_wr state=%0d ack/vs/wr=%b exp 18 011", state_o, {irq_ack, vector_sel, regWriteEN}); end
        step;
        checks++; if (state_o !== S_FETCH || vector_sel !== 1'b0) begin failures++; $display("FAIL irq_done state=%0d vs=%b exp 0 0", state_o, vector_sel); end
        PSR = 8'h00; irq = 1'b1;
        to_decode; step; step; step;
        checks++; if (state_o !== S_FETCH || irq_ack !== 1'b0) begin failures++; $display("FAIL irq_masked state=%0d ack=%b exp 0 0", state_o, irq_ack); end
        irq = 1'b0;
    endtask

    task automatic test_sb_reset;
        opCode1 = 4'h4; opCode2 = 4'h4;
        to_decode; step; step;
        checks++; if (state_o !== S_SBWR || {wren_a, storeReg, updateAddress} !== 3'b110) begin failures++; $display("FAIL sb_wait state=%0d we/st/upd=%b exp 12 110", state_o, {wren_a, storeReg, updateAddress}); end
        step;
        #20 reset = 1'b0;
        #1;
        checks++; if (state_o !== S_FETCH || wren_a !== 1'b0 || PCEN !== 1'b1) begin failures++; $display("FAIL sb_async_rst state=%0d wren=%b pcen=%b exp 0 0 1", state_o, wren_a, PCEN); end
        #40 reset = 1'b1;
        step;
        checks++; if (state_o !== S_FWAIT) begin failures++; $display("FAIL sb_post_rst got=%0d exp=%0d", state_o, S_FWAIT); end
        step; step; step; step;
        mem_ready = 1'b1;
        step;
        mem_ready = 1'b0;
        checks++; if (state_o !== S_FETCH || wren_a !== 1'b0 || mem_err !== 1'b0) begin failures++; $display("FAIL sb_ready state=%0d wren=%b err=%b exp 0 0 0", state_o, wren_a, mem_err); end
        opCode2 = 4'h1;
        to_decode; step;
        checks++; if (state_o !== S_MEMADR || illegal !== 1'b1) begin failures++; $display("FAIL illegal_op2 state=%0d illegal=%b exp 9 1", state_o, illegal); end
        step;
        checks++; if (state_o !== S_FETCH || illegal !== 1'b0) begin failures++; $display("FAIL illegal_op2_done state=%0d illegal=%b exp 0 0", state_o, illegal); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_lb;
        test_lb_timeout;
        test_rtype;
        test_bcond;
        test_irq;
        test_sb_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
